// File: rtl/addsub_issue_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : addsub_issue_stage
// Purpose  : Issue stage wrapped around an external combinational unsigned
//            WIDTH-bit adder/subtractor. Operand transactions are buffered
//            in a DEPTH-entry FIFO; the FIFO head drives the adder, and the
//            returned result is captured with carry/borrow and zero flags in
//            an output register that has its own valid/ready handshake.
// Ports    : clk, rst_n              - clock, async active-low reset
//            in_valid/in_ready       - upstream handshake
//            in_a, in_b, in_addsub   - operands and op (0 add, 1 subtract)
//            add_a, add_b, add_addsub- FIFO head to the adder (zero if empty)
//            add_res                 - combinational result from the adder
//            out_valid/out_ready     - downstream handshake
//            out_res, out_carry,
//            out_zero                - registered result and flags
//            count                   - FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module addsub_issue_stage #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_a,
   input  logic [WIDTH-1:0]           in_b,
   input  logic                       in_addsub,
   output logic [WIDTH-1:0]           add_a,
   output logic [WIDTH-1:0]           add_b,
   output logic                       add_addsub,
   input  logic [WIDTH-1:0]           add_res,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_res,
   output logic                       out_carry,
   output logic                       out_zero,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int                  c_PTR_W   = $clog2(DEPTH);
   localparam logic [c_PTR_W:0]    c_FULL    = (c_PTR_W+1)'(DEPTH);
   localparam logic [c_PTR_W-1:0]  c_PTR_ONE = (c_PTR_W)'(1);
   localparam logic [c_PTR_W:0]    c_CNT_ONE = (c_PTR_W+1)'(1);

   // FIFO storage (no reset: contents are only visible through count)
   logic [WIDTH-1:0]   r_mem_a  [DEPTH];
   logic [WIDTH-1:0]   r_mem_b  [DEPTH];
   logic               r_mem_op [DEPTH];

   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W:0]   r_count;

   logic               r_out_valid;
   logic [WIDTH-1:0]   r_out_res;
   logic               r_out_carry;
   logic               r_out_zero;

   logic               w_nonempty;
   logic               w_push;
   logic               w_load;
   logic               w_carry;

   // Ready comes purely from registered occupancy, so a pop in the same
   // cycle never opens a slot for a push while full.
   assign in_ready   = (r_count != c_FULL);
   assign w_nonempty = (r_count != '0);
   assign w_push     = in_valid & in_ready;
   assign w_load     = w_nonempty & (~r_out_valid | out_ready);

   // Head entry to the adder; forced to zero when the FIFO is empty.
   assign add_a      = w_nonempty ? r_mem_a[r_rd_ptr]  : '0;
   assign add_b      = w_nonempty ? r_mem_b[r_rd_ptr]  : '0;
   assign add_addsub = w_nonempty ? r_mem_op[r_rd_ptr] : 1'b0;

   // Carry is recovered from the truncated sum (wrap means res < a);
   // borrow is simply a < b.
   assign w_carry = add_addsub ? (add_a < add_b) : (add_res < add_a);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_a[r_wr_ptr]  <= in_a;
         r_mem_b[r_wr_ptr]  <= in_b;
         r_mem_op[r_wr_ptr] <= in_addsub;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         if (w_load) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         case ({w_push, w_load})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_res   <= '0;
         r_out_carry <= 1'b0;
         r_out_zero  <= 1'b0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_res   <= add_res;
         r_out_carry <= w_carry;
         r_out_zero  <= (add_res == '0);
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_res   = r_out_res;
   assign out_carry = r_out_carry;
   assign out_zero  = r_out_zero;
   assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_addsub_issue_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_addsub_issue_stage
// Purpose  : Self-checking bench for addsub_issue_stage. Provides the
//            combinational adder, a queue-based reference model, a per-cycle
//            compare process and directed plus randomized stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_issue_stage;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_addsub;
   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic             add_addsub;
   logic [WIDTH-1:0] add_res;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_res;
   logic             out_carry;
   logic             out_zero;
   logic [$clog2(DEPTH):0] count;

   int checks = 0;
   int errors = 0;

   addsub_issue_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_addsub  (in_addsub),
      .add_a      (add_a),
      .add_b      (add_b),
      .add_addsub (add_addsub),
      .add_res    (add_res),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_res    (out_res),
      .out_carry  (out_carry),
      .out_zero   (out_zero),
      .count      (count)
   );

   // external combinational adder/subtractor
   assign add_res = add_addsub ? (add_a - add_b) : (add_a + add_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: a queue of pending operations plus one result slot
   // ------------------------------------------------------------------
   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             op;
   } txn_t;

   txn_t             m_q[$];
   logic             m_valid = 1'b0;
   logic [WIDTH-1:0] m_res   = '0;
   logic             m_carry = 1'b0;
   logic             m_zero  = 1'b0;
   int               accepted = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_valid = 1'b0;
         m_res   = '0;
         m_carry = 1'b0;
         m_zero  = 1'b0;
      end else begin
         bit   do_push;
         bit   do_load;
         txn_t t;
         logic [WIDTH:0] wide;
         do_push = in_valid && (m_q.size() < DEPTH);
         do_load = (m_q.size() > 0) && (!m_valid || out_ready);
         if (do_load) begin
            t = m_q.pop_front();
            if (t.op) begin
               wide    = {1'b0, t.a} - {1'b0, t.b};
               m_carry = (int'(t.a) < int'(t.b));
            end else begin
               wide    = {1'b0, t.a} + {1'b0, t.b};
               m_carry = wide[WIDTH];
            end
            m_res   = wide[WIDTH-1:0];
            m_zero  = (m_res == 0);
            m_valid = 1'b1;
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
         if (do_push) begin
            m_q.push_back('{a: in_a, b: in_b, op: in_addsub});
            accepted++;
         end
      end
   end

   // ------------------------------------------------------------------
   // Compare process, on the falling edge
   // ------------------------------------------------------------------
   bit               prev_stall = 0;
   logic [WIDTH-1:0] prev_res   = '0;

   always @(negedge clk) begin
      if (rst_n) begin
         txn_t h;
         h = (m_q.size() > 0) ? m_q[0] : '0;
         check("in_ready",   32'(in_ready),   32'(m_q.size() != DEPTH));
         check("count",      32'(count),      32'(m_q.size()));
         check("count_max",  32'(count <= DEPTH), 32'd1);
         check("add_a",      32'(add_a),      32'(h.a));
         check("add_b",      32'(add_b),      32'(h.b));
         check("add_addsub", 32'(add_addsub), 32'(h.op));
         check("out_valid",  32'(out_valid),  32'(m_valid));
         check("out_res",    32'(out_res),    32'(m_res));
         check("out_carry",  32'(out_carry),  32'(m_carry));
         check("out_zero",   32'(out_zero),   32'(m_zero));
         if (prev_stall) check("stall_stable", 32'(out_res), 32'(prev_res));
         prev_stall = out_valid && !out_ready;
         prev_res   = out_res;
      end else begin
         prev_stall = 0;
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Single transaction into an idle stage; checks latency and literal result.
   task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic op, input int exp_res, input int exp_c,
                        input int exp_z, input string name);
      out_ready = 1'b1;
      in_valid  = 1'b0;
      repeat (3) step();
      check({name, "_ready"}, 32'(in_ready), 32'd1);
      in_a = a; in_b = b; in_addsub = op; in_valid = 1'b1;
      step();                           // edge N: accepted
      in_valid = 1'b0;
      check({name, "_lat_n"}, 32'(out_valid), 32'd0);
      step();                           // edge N+1: loaded
      check({name, "_valid"}, 32'(out_valid), 32'd1);
      check({name, "_res"},   32'(out_res),   32'(exp_res));
      check({name, "_carry"}, 32'(out_carry), 32'(exp_c));
      check({name, "_zero"},  32'(out_zero),  32'(exp_z));
   endtask

   // Offer transactions k=1..n (a=10k, b=k, add) with out_ready low.
   task automatic fill(input int n, output int acc);
      int idx;
      bit will;
      idx = 0;
      out_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
         in_a = WIDTH'(10 * (idx + 1)); in_b = WIDTH'(idx + 1);
         in_addsub = 1'b0; in_valid = 1'b1;
         will = in_ready;
         step();
         if (will) idx++;
      end
      in_valid = 1'b0;
      acc = idx;
   endtask

   task automatic drain(input string name);
      int cyc;
      cyc = 0;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      while ((m_q.size() != 0 || m_valid || out_valid) && cyc < 100) begin
         step();
         cyc++;
      end
      check({name, "_drained"}, 32'(out_valid || (count != 0)), 32'd0);
   endtask

   // ------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------
   initial begin
      int acc;
      int start;
      int cyc;

      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
      in_addsub = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      step();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_count",     32'(count),     32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_res",   32'(out_res),   32'd0);

      // 1. async reset mid-operation
      fill(3, acc);
      check("t1_valid_before", 32'(out_valid), 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t1_async_valid", 32'(out_valid), 32'd0);
      check("t1_async_count", 32'(count),     32'd0);
      check("t1_async_res",   32'(out_res),   32'd0);
      check("t1_async_carry", 32'(out_carry), 32'd0);
      #10 rst_n = 1'b1;
      step();
      check("t1_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      repeat (3) begin
         step();
         check("t1_no_stale", 32'(out_valid), 32'd0);
      end

      // 2/3. directed arithmetic with literal expectations
      do_op(8'd200, 8'd100, 1'b0, 44,  1, 0, "add_wrap");
      do_op(8'd17,  8'd25,  1'b0, 42,  0, 0, "add_small");
      do_op(8'd5,   8'd5,   1'b1, 0,   0, 1, "sub_zero");
      do_op(8'd3,   8'd10,  1'b1, 249, 1, 0, "sub_borrow");
      do_op(8'd255, 8'd0,   1'b1, 255, 0, 0, "sub_max");
      do_op(8'd128, 8'd128, 1'b0, 0,   1, 1, "add_zero_carry");
      drain("t3");

      // 4. backpressure
      fill(7, acc);
      check("t4_accepted", 32'(acc),      32'd5);
      check("t4_in_ready", 32'(in_ready), 32'd0);
      check("t4_count",    32'(count),    32'd4);
      check("t4_res1",     32'(out_res),  32'd11);
      out_ready = 1'b1;
      for (int k = 2; k <= 5; k++) begin
         step();
         if (k == 2) check("t4_ready_rise", 32'(in_ready), 32'd1);
         check("t4_drain_valid", 32'(out_valid), 32'd1);
         check("t4_drain_res",   32'(out_res),   32'(11 * k));
      end
      step();
      check("t4_empty", 32'(out_valid), 32'd0);

      // 6. full plus simultaneous push/pop with pointer wrap
      fill(6, acc);
      check("t6_full", 32'(count), 32'd4);
      in_a = 8'd250; in_b = 8'd9; in_addsub = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      check("t6_no_push", 32'(count), 32'd3);
      for (int i = 0; i < 7; i++) begin
         in_a = WIDTH'($urandom); in_b = WIDTH'($urandom); in_addsub = 1'($urandom);
         step();
         check("t6_hold3", 32'(count), 32'd3);
      end
      drain("t6");

      // 5. randomized streaming
      start = accepted;
      cyc = 0;
      while ((accepted - start) < 64 && cyc < 3000) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_a      = WIDTH'($urandom);
         in_b      = ($urandom_range(0, 7) == 0) ? in_a : WIDTH'($urandom);
         in_addsub = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         step();
         cyc++;
      end
      in_valid = 1'b0;
      check("t5_accepted", 32'((accepted - start) >= 64), 32'd1);
      drain("t5");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout required completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
